// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the AES pipeline arbiter: block/tag types and core latency.
package aes_arb_pkg;

    localparam int ID_W_MAX = 4;

    typedef logic [3:0][3:0][7:0] block_t;

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

    function automatic int core_lat(input int keylen);
        return keylen / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_pipe_arbiter_if.sv
// Requester, encrypt-core and output-stream signals of the AES pipeline arbiter.
// The arbiter connects through the slave modport; the environment drives through master.
interface aes_pipe_arbiter_if
    import aes_arb_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic   [NREQ-1:0]         req_valid;
    logic   [NREQ-1:0]         req_ready;
    block_t [NREQ-1:0]         req_data;
    logic                      core_valid_in;
    block_t                    core_plaintext;
    logic                      core_valid_out;
    block_t                    core_ciphertext;
    logic                      out_valid;
    logic                      out_ready;
    logic   [IDW-1:0]          out_id;
    block_t                    out_data;

    modport master (
        output req_valid, req_data, core_valid_out, core_ciphertext, out_ready,
        input  req_ready, core_valid_in, core_plaintext, out_valid, out_id, out_data
    );

    modport slave (
        input  req_valid, req_data, core_valid_out, core_ciphertext, out_ready,
        output req_ready, core_valid_in, core_plaintext, out_valid, out_id, out_data
    );

endinterface

// File: rtl/aes_arb_fifo.sv
// First-word-fall-through FIFO; the head entry is visible on rd_data while rd_valid is high,
// and reads as zero when empty.
module aes_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic             full, do_wr, do_rd;

    assign full  = (count_reg == CW'(DEPTH));
    assign do_rd = rd_en && (count_reg != '0);
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (do_wr && !do_rd) begin
            count_next = count_reg + CW'(1);
        end else if (!do_wr && do_rd) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (do_wr) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
            end
        end
    end

    assign rd_valid = (count_reg != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
    assign count    = count_reg;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full && !do_rd));

endmodule

// File: rtl/aes_pipe_arbiter.sv
// Round-robin sharing of one pipelined AES encrypt core; issue is credit-gated against
// output FIFO space. Optional per-requester statistics when AES_ARB_STATS_EN is defined.
module aes_pipe_arbiter
    import aes_arb_pkg::*;
#(
    parameter int KEYLEN     = 128,
    parameter int NREQ       = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_pipe_arbiter_if.slave     bus
`ifdef AES_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][31:0] stat_issued,
    output logic [31:0]           stat_stall_cycles
`endif
);
    localparam int CORE_LAT = core_lat(KEYLEN);
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    localparam int FW       = 128 + IDW;

    if (FIFO_DEPTH < CORE_LAT + 1 || NREQ < 2 || NREQ > 16) begin : g_bad_cfg
        $error("aes_pipe_arbiter: need FIFO_DEPTH >= CORE_LAT+1 and 2 <= NREQ <= 16");
    end

    logic [CW-1:0]   credits_reg, credits_next;
    logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [IDW-1:0]  cand_idx [NREQ];
    logic [IDW-1:0]  grant_idx;
    logic            grant_found;
    logic [NREQ-1:0] grant_vec;
    logic            accept, pop;
    logic            core_valid_in_reg;
    block_t          core_plaintext_reg;
    tag_t            tag_pipe_reg [CORE_LAT+1];
    tag_t            tail_tag;
    logic [FW-1:0]   fifo_rd_data;
    logic [CW-1:0]   fifo_count;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand_idx[gi] = IDW'((int'(rr_ptr_reg) + gi) % NREQ);
    end

    // Nearest valid requester at or after rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && bus.req_valid[cand_idx[i]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[i];
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign grant_vec[gi] = grant_found && (credits_reg != '0) && (grant_idx == IDW'(gi));
    end

    assign bus.req_ready = grant_vec;
    assign accept        = |(bus.req_valid & grant_vec);
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        credits_next = credits_reg;
        rr_ptr_next  = rr_ptr_reg;
        if (accept && !pop) begin
            credits_next = credits_reg - CW'(1);
        end else if (!accept && pop) begin
            credits_next = credits_reg + CW'(1);
        end
        if (accept) begin
            rr_ptr_next = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_reg        <= CW'(FIFO_DEPTH);
            rr_ptr_reg         <= '0;
            core_valid_in_reg  <= 1'b0;
            core_plaintext_reg <= '0;
        end else begin
            credits_reg       <= credits_next;
            rr_ptr_reg        <= rr_ptr_next;
            core_valid_in_reg <= accept;
            if (accept) begin
                core_plaintext_reg <= bus.req_data[grant_idx];
            end
        end
    end

    assign bus.core_valid_in  = core_valid_in_reg;
    assign bus.core_plaintext = core_plaintext_reg;

    // Stage 0 loads together with core_valid_in, so the last stage lines up with core_valid_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pipe_reg[0] <= '0;
        end else begin
            tag_pipe_reg[0] <= '{valid: accept, id: ID_W_MAX'(grant_idx)};
        end
    end

    for (genvar gi = 1; gi <= CORE_LAT; gi++) begin : g_tag_pipe
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tag_pipe_reg[gi] <= '0;
            end else begin
                tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
            end
        end
    end

    assign tail_tag = tag_pipe_reg[CORE_LAT];

    aes_arb_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.core_valid_out),
        .wr_data  ({tail_tag.valid ? tail_tag.id[IDW-1:0] : IDW'(0), bus.core_ciphertext}),
        .rd_en    (bus.out_ready),
        .rd_data  (fifo_rd_data),
        .rd_valid (bus.out_valid),
        .count    (fifo_count)
    );

    assign bus.out_id   = fifo_rd_data[FW-1 -: IDW];
    assign bus.out_data = fifo_rd_data[127:0];

    a_tag_match: assert property (@(posedge clk) disable iff (rst)
        bus.core_valid_out |-> tail_tag.valid);
    a_tag_range: assert property (@(posedge clk) disable iff (rst)
        tail_tag.valid |-> (int'(tail_tag.id) < NREQ));
    a_credit_sum: assert property (@(posedge clk) disable iff (rst)
        (int'(fifo_count) + int'(credits_reg)) <= FIFO_DEPTH);

`ifdef AES_ARB_STATS_EN
    logic [31:0] issued_reg [NREQ];
    logic [31:0] stall_reg;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat_issued
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                issued_reg[gi] <= '0;
            end else if (bus.req_valid[gi] && grant_vec[gi]) begin
                issued_reg[gi] <= issued_reg[gi] + 32'd1;
            end
        end
        assign stat_issued[gi] = issued_reg[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_reg <= '0;
        end else if ((|bus.req_valid) && (credits_reg == '0)) begin
            stall_reg <= stall_reg + 32'd1;
        end
    end

    assign stat_stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_aes_pipe_arbiter.sv
// Directed bench for aes_pipe_arbiter with a 10-cycle behavioural core model.
module tb_aes_pipe_arbiter;
    import aes_arb_pkg::*;

    localparam int LAT = 10;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RR_BASE = 128'hfeed0000_00000000_00000000_00000000;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    aes_pipe_arbiter_if #(.NREQ(4)) bus ();

`ifdef AES_ARB_STATS_EN
    logic [3:0][31:0] stat_issued;
    logic [31:0]      stat_stall_cycles;
`endif

    aes_pipe_arbiter #(
        .KEYLEN     (128),
        .NREQ       (4),
        .FIFO_DEPTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef AES_ARB_STATS_EN
        ,
        .stat_issued       (stat_issued),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    function automatic logic [127:0] enc(input logic [127:0] pt);
        return (pt == FIPS_PT) ? FIPS_CT : (pt ^ 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c);
    endfunction

    // Encrypt-core model: fixed latency, no stall, cleared by reset.
    logic         cv_pipe [LAT];
    logic [127:0] cd_pipe [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                cv_pipe[i] <= 1'b0;
                cd_pipe[i] <= '0;
            end
        end else begin
            cv_pipe[0] <= bus.core_valid_in;
            cd_pipe[0] <= enc(bus.core_plaintext);
            for (int i = 1; i < LAT; i++) begin
                cv_pipe[i] <= cv_pipe[i-1];
                cd_pipe[i] <= cd_pipe[i-1];
            end
        end
    end

    assign bus.core_valid_out  = cv_pipe[LAT-1];
    assign bus.core_ciphertext = cd_pipe[LAT-1];

    task automatic check_val(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_req_ready"}, bus.req_ready, 0);
        check_val({tag, "_core_valid_in"}, bus.core_valid_in, 0);
        check_val({tag, "_core_plaintext"}, bus.core_plaintext, 0);
        check_val({tag, "_out_valid"}, bus.out_valid, 0);
        check_val({tag, "_out_id"}, bus.out_id, 0);
        check_val({tag, "_out_data"}, bus.out_data, 0);
        check_val({tag, "_credits"}, dut.credits_reg, 16);
    endtask

    int n;
    int acc;
    int stale;

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_data[i] = RR_BASE + 128'(i);
        end

        // Reset state
        @(negedge clk);
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single request from requester 2 with the FIPS-197 vector
        @(negedge clk);
        bus.req_data[2] = FIPS_PT;
        bus.req_valid   = 4'b0100;
        #1;
        check_val("single_grant", bus.req_ready, 4'b0100);
        @(negedge clk);
        check_val("single_core_valid_in", bus.core_valid_in, 1);
        check_val("single_core_plaintext", bus.core_plaintext, FIPS_PT);
        bus.req_valid   = '0;
        bus.req_data[2] = RR_BASE + 128'd2;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("single_latency", n, 12);
        check_val("single_out_id", bus.out_id, 2);
        check_val("single_out_data", bus.out_data, FIPS_CT);

        // Round robin from a fresh pointer, all requesters valid, downstream always ready
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'hf;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_val($sformatf("rr_grant_%0d", k), bus.req_ready, 4'b0001 << (k % 4));
            @(negedge clk);
        end
        bus.req_valid = '0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("rr_first_out_wait", n, 4);
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("rr_out_valid_%0d", k), bus.out_valid, 1);
            check_val($sformatf("rr_out_id_%0d", k), bus.out_id, k % 4);
            check_val($sformatf("rr_out_data_%0d", k), bus.out_data, enc(RR_BASE + 128'(k % 4)));
            @(negedge clk);
        end

        // Downstream stalled: requester 0 streams until credits run out
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0001;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.req_ready[0]) acc++;
            @(negedge clk);
        end
        check_val("stall_accepts", acc, 16);
        check_val("stall_req_ready", bus.req_ready, 0);
        check_val("stall_fifo_count", dut.u_fifo.count_reg, 16);
        check_val("stall_credits", dut.credits_reg, 0);
        check_val("stall_out_valid", bus.out_valid, 1);
        check_val("stall_out_id", bus.out_id, 0);
        bus.out_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.req_ready[0]) acc++;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        check_val("stall_one_more_accept", acc, 1);
        bus.req_valid = '0;
        repeat (15) @(negedge clk);
        check_val("stall_refill_count", dut.u_fifo.count_reg, 16);

        // Credit boundary: credits==1 with issue and pop in the same cycle
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check_val("cb_credits_before", dut.credits_reg, 1);
        bus.req_valid = 4'b0001;
        bus.out_ready = 1'b1;
        #1;
        check_val("cb_grant_first", bus.req_ready, 4'b0001);
        @(negedge clk);
        #1;
        check_val("cb_credits_after", dut.credits_reg, 1);
        check_val("cb_grant_again", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        repeat (40) @(negedge clk);
        check_val("cb_drained_credits", dut.credits_reg, 16);
        check_val("cb_drained_out_valid", bus.out_valid, 0);

        // Asynchronous reset with five blocks in flight
        bus.req_valid = 4'hf;
        repeat (5) @(posedge clk);
        #1;
        bus.req_valid = '0;
        check_val("ar_pre_core_valid_in", bus.core_valid_in, 1);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("ar");
        @(negedge clk);
        rst   = 1'b0;
        stale = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check_val("ar_no_stale_out", stale, 0);
        check_val("ar_credits", dut.credits_reg, 16);

`ifdef AES_ARB_STATS_EN
        // Statistics: 3 accepts from requester 1, 13 from requester 0, then 4 stalled cycles
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0010;
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = 4'b0001;
        repeat (13) @(posedge clk);
        #1;
        bus.req_valid = 4'b0010;
        repeat (4) @(posedge clk);
        #1;
        bus.req_valid = '0;
        check_val("stat_issued_1", stat_issued[1], 3);
        check_val("stat_issued_0", stat_issued[0], 13);
        check_val("stat_stall_cycles", stat_stall_cycles, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_pipe_arbiter.md
Name: aes_pipe_arbiter

Overview:
- Shares one pipelined AES block-encrypt core among NREQ requesters.
- Round-robin arbitration picks one plaintext block per cycle, issues it to the core and tracks the requester ID alongside it.
- Results are collected into an output FIFO.
- The core has no stall input, so issue is credit-gated: a block is never issued unless an output FIFO slot is already reserved for it.

Parameters:
- KEYLEN, 128: AES key length (128/192/256). Sets core latency CORE_LAT = KEYLEN/32+6 cycles (10 for AES-128).
- NREQ, 4: number of requesters, range 2..16.
- FIFO_DEPTH, 16: output FIFO entries; must be ≥ CORE_LAT+1 (checked by elaboration assertion).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester block valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_data  in  NREQ×128  per-requester plaintext, packed [NREQ-1:0][127:0]
- core_valid_in  out  1  issue strobe to the encrypt core
- core_plaintext  out  128  block issued to the core
- core_valid_out  in  1  core result strobe
- core_ciphertext  in  128  core result
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accept
- out_id  out  $clog2(NREQ)  requester ID of the head entry
- out_data  out  128  ciphertext of the head entry

Behaviour:
- Reset values: req_ready=0, core_valid_in=0, core_plaintext=0, out_valid=0, out_id=0, out_data=0. RR pointer=0, credits=FIFO_DEPTH, tag pipe cleared, FIFO empty. Reset is asynchronous, so a reset mid-operation discards all in-flight blocks.
- Credits:
  - credit counter is $clog2(FIFO_DEPTH+1) bits.
  - Decrement on issue; increment on out_valid&&out_ready.
  - Both in the same cycle: no change.
  - Counter never exceeds FIFO_DEPTH and never goes below 0.
- Grant (combinational on the current cycle):
  - If credits>0, grant the first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[g]=1 only for the granted index; all zero when credits==0.
- Issue:
  - Happens on req_valid[g]&&req_ready[g].
  - Registered: core_valid_in=1 and core_plaintext=req_data[g] on the next edge.
  - Issue latency is 1 cycle from accept to core input.
  - On issue, rr_ptr ← g+1 mod NREQ. With no issue, rr_ptr holds.
- Tag pipe:
  - Shift register of CORE_LAT+1 stages carrying {valid,id}, advancing every cycle, aligned with core_valid_in→core_valid_out.
  - When core_valid_out=1, write {tag id, core_ciphertext} into the FIFO.
  - core_valid_out without a matching tag valid is a protocol error. The result is still written, with id 0, and an assertion fires.
- End-to-end latency: accept → out_valid = 1 + CORE_LAT + 1 cycles (12 for AES-128) when the FIFO is empty. The FIFO write is registered.
- FIFO:
  - First-word-fall-through; out_* reflect the head entry.
  - Simultaneous write and read at any fill level is legal.
  - Overflow cannot occur by construction (credits). An assertion checks it.
- out_ready=0 indefinitely: the arbiter stalls once credits reach 0. In-flight blocks still drain into the reserved slots. Nothing is lost.
- Throughput: 1 block/cycle sustained while downstream accepts every cycle.

Optional Feature:
- Macro: AES_ARB_STATS_EN.
- Defined:
  - Adds an output port stat_issued, NREQ×32: per-requester 32-bit wrapping counters of accepted blocks.
  - Adds an output port stat_stall_cycles, 32 bits: cycles where any req_valid=1 but credits==0.
  - All counters reset to 0.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package aes_arb_pkg holds:
  - function core_lat(keylen) returning keylen/32+6
  - typedef block_t = logic [3:0][3:0][7:0]
  - typedef tag_t = struct {valid, id}
- Natural sub-module: aes_arb_fifo, a parameterized FWFT FIFO (width, depth) with count output, instantiated once with width 128+$clog2(NREQ).
- The RR grant stays inline.

Test Plan:
- Single request: req_valid[2]=1 with data 0x00112233445566778899aabbccddeeff; core model returns the FIPS-197 key-0x000102..0f result.
  - Required: core_valid_in 1 cycle after accept.
  - Required: out_valid 12 cycles after accept, out_id=2, out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- All 4 requesters valid continuously, out_ready=1: grants are 0,1,2,3,0,1… with one accept per cycle, and out_id follows the same sequence.
- out_ready=0, requester 0 streaming:
  - exactly 16 accepts, then req_ready stays 0;
  - the FIFO fills to 16 with no overflow.
  - Raise out_ready for 1 cycle: exactly one further accept.
- Credit boundary: credits=1 with a simultaneous issue and out pop in the same cycle → credits stay 1 and the next cycle grants again.
- Async reset asserted mid-stream with 5 blocks in flight:
  - outputs are 0 immediately;
  - after release, no stale out_valid appears (the core model is also reset);
  - credits=16.
- AES_ARB_STATS_EN defined, 3 accepts from requester 1 and 4 stall cycles → stat_issued[1]=3, stat_stall_cycles=4.
